// File: rtl/pyrconstuct_mul_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : pyrconstuct_mul_share_arb
// Purpose  : Round-robin scheduler that shares one unsigned-9 x signed-24
//            multiplier (low 32 bits of the product) among NUM_REQ
//            requesters. Two-stage pipeline: S1 holds the operands, S2 holds
//            the product and drives the shared response bus.
// Ports    : ap_clk, ap_rst  - clock / asynchronous active-high reset
//            req_valid/ready - per-requester handshake (ready is one-hot or 0)
//            req_a, req_b    - packed per-requester operands (9b / 24b)
//            rsp_valid/ready - response handshake with backpressure
//            rsp_id, rsp_p   - requester tag and 32-bit two's-complement product
//            busy            - any pipeline stage holds a valid operation
// Revision : 1.0 - initial release
// ============================================================================
module pyrconstuct_mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [9*NUM_REQ-1:0]  req_a,
  input  logic [24*NUM_REQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_p,
  output logic                  busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Pipeline and arbitration state
  logic [IDX_W-1:0] ptr_q,  ptr_d;
  logic             v1_q,   v1_d;
  logic [8:0]       a1_q,   a1_d;
  logic [23:0]      b1_q,   b1_d;
  logic [IDX_W-1:0] id1_q,  id1_d;
  logic             v2_q,   v2_d;
  logic [31:0]      p2_q,   p2_d;
  logic [ID_W-1:0]  id2_q,  id2_d;

  logic             adv1;
  logic             adv2;
  logic             accept;
  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic [8:0]       grant_a;
  logic [23:0]      grant_b;
  logic [IDX_W:0]   cand;
  logic [31:0]      prod_lo;

  // S2 frees up when empty or draining; S1 frees up when empty or moving on.
  assign adv2 = !v2_q || rsp_ready;
  assign adv1 = !v1_q || adv2;

  // Round-robin search starting at ptr_q; cand is one bit wider so the
  // modulo wrap works for non-power-of-two NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Operand mux for the granted requester
  always_comb begin
    grant_a = '0;
    grant_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        grant_a = req_a[9*i +: 9];
        grant_b = req_b[24*i +: 24];
      end
    end
  end

  // Ready is held low during reset so nothing is accepted into a pipeline
  // that is being cleared.
  assign accept = grant_found && adv1 && !ap_rst;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = accept && (grant_idx == IDX_W'(gi));
  end

  // Both operands are widened to 32 bits with sign extension (a is made
  // non-negative by its zero MSB first). The 32-bit product modulo 2^32 is
  // exactly the low 32 bits of the full 34-bit product, so the top two
  // bits are dropped without saturation.
  assign prod_lo = 32'($signed({1'b0, a1_q})) * 32'($signed(b1_q));

  always_comb begin
    ptr_d = ptr_q;
    v1_d  = v1_q;
    a1_d  = a1_q;
    b1_d  = b1_q;
    id1_d = id1_q;
    v2_d  = v2_q;
    p2_d  = p2_q;
    id2_d = id2_q;

    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        p2_d  = prod_lo;
        id2_d = ID_W'(id1_q);
      end
    end

    if (adv1) begin
      v1_d = accept;
      if (accept) begin
        a1_d  = grant_a;
        b1_d  = grant_b;
        id1_d = grant_idx;
      end
    end

    if (accept) begin
      if (grant_idx == IDX_W'(NUM_REQ-1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ptr_q <= '0;
      v1_q  <= 1'b0;
      a1_q  <= '0;
      b1_q  <= '0;
      id1_q <= '0;
      v2_q  <= 1'b0;
      p2_q  <= '0;
      id2_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      v1_q  <= v1_d;
      a1_q  <= a1_d;
      b1_q  <= b1_d;
      id1_q <= id1_d;
      v2_q  <= v2_d;
      p2_q  <= p2_d;
      id2_q <= id2_d;
    end
  end

  assign rsp_valid = v2_q;
  assign rsp_id    = id2_q;
  assign rsp_p     = p2_q;
  assign busy      = v1_q || v2_q;

endmodule
`default_nettype wire

// File: tb/tb_pyrconstuct_mul_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_pyrconstuct_mul_share_arb
// Purpose  : Directed self-checking bench for pyrconstuct_mul_share_arb.
//            A small arbitration/pipeline model predicts req_ready and pushes
//            expected (id, product) pairs into a scoreboard queue on every
//            accept; responses are popped and compared when they appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pyrconstuct_mul_share_arb;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [35:0] req_a;
  logic [95:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_p;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] p;
  } exp_t;

  exp_t        exp_q[$];
  int          ptr_m;
  bit          v1m;
  bit          v2m;
  bit          s_adv1;
  bit          s_adv2;
  int          s_grant;
  logic [31:0] s_p;

  logic [3:0] t3_seq [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [3:0] t5_seq [3] = '{4'b1000, 4'b0010, 4'b1000};

  pyrconstuct_mul_share_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mul_ref(input logic [8:0] a, input logic [23:0] b);
    logic signed [33:0] full;
    full = $signed({1'b0, a}) * $signed(b);
    return full[31:0];
  endfunction

  function automatic int model_grant();
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (ptr_m + k) % NUM_REQ;
      if (req_valid[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    v1m   = 1'b0;
    v2m   = 1'b0;
    ptr_m = 0;
  endtask

  task automatic set_op(input int i, input logic [8:0] a, input logic [23:0] b);
    req_a[9*i +: 9]   = a;
    req_b[24*i +: 24] = b;
  endtask

  task automatic rand_ops();
    req_a = 36'({$urandom(), $urandom()});
    req_b = {$urandom(), $urandom(), $urandom()};
  endtask

  // Called at the falling edge with inputs already driven.
  task automatic sample();
    logic [3:0] exp_rdy;
    #1;
    s_adv2  = !v2m || rsp_ready;
    s_adv1  = !v1m || s_adv2;
    s_grant = s_adv1 ? model_grant() : -1;
    exp_rdy = '0;
    if (s_grant >= 0) begin
      exp_rdy[s_grant[1:0]] = 1'b1;
      s_p = mul_ref(req_a[9*s_grant +: 9], req_b[24*s_grant +: 24]);
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(v2m));
    if (v2m && exp_q.size() > 0) begin
      chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
      chk("rsp_p", rsp_p, exp_q[0].p);
    end
    chk("busy", 32'(busy), 32'(v1m | v2m));
  endtask

  task automatic tick();
    exp_t e;
    @(posedge ap_clk);
    if (s_adv2) begin
      if (v2m && rsp_ready) void'(exp_q.pop_front());
      v2m = v1m;
    end
    if (s_adv1) begin
      v1m = (s_grant >= 0);
      if (s_grant >= 0) begin
        e.id = 2'(s_grant);
        e.p  = s_p;
        exp_q.push_back(e);
        ptr_m = (s_grant + 1) % NUM_REQ;
      end
    end
    @(negedge ap_clk);
  endtask

  task automatic step();
    sample();
    tick();
  endtask

  initial begin
    ap_rst    = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_p", rsp_p, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;

    // All requesters valid from ptr=0: strict rotation
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      sample();
      chk("t3_grant", 32'(req_ready), 32'(t3_seq[i]));
      tick();
    end
    req_valid = 4'h0;
    repeat (2) step();

    // Only 1 and 3 valid with ptr=2: 3, wrap to 1, then 3
    req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      sample();
      chk("t5_grant", 32'(req_ready), 32'(t5_seq[i]));
      tick();
    end
    req_valid = 4'h0;
    repeat (2) step();

    // Single op from requester 2, two-cycle latency
    set_op(2, 9'd255, 24'hFFFFFF);
    req_valid = 4'b0100;
    sample();
    chk("t1_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'h0;
    sample();
    chk("t1_lat1_valid", 32'(rsp_valid), 32'd0);
    tick();
    sample();
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_id", 32'(rsp_id), 32'd2);
    chk("t1_p", rsp_p, 32'hFFFFFF01);
    tick();

    // Truncation of the 34-bit product
    req_valid = 4'b0001;
    set_op(0, 9'd511, 24'h7FFFFF);
    step();
    set_op(0, 9'd256, 24'h800000);
    step();
    req_valid = 4'h0;
    sample();
    chk("t2_p_max", rsp_p, 32'hFF7FFE01);
    tick();
    sample();
    chk("t2_p_min", rsp_p, 32'h80000000);
    tick();

    // Backpressure with both stages full
    set_op(1, 9'd300, 24'hFFCFC7);
    set_op(2, 9'd7, 24'd100000);
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0100;
    step();
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("t4_hold_ready", 32'(req_ready), 32'd0);
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_id", 32'(rsp_id), 32'd1);
      chk("t4_hold_p", rsp_p, 32'hFFC77D34);
      tick();
    end
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    sample();
    chk("t4_rel1_id", 32'(rsp_id), 32'd1);
    tick();
    sample();
    chk("t4_rel2_valid", 32'(rsp_valid), 32'd1);
    chk("t4_rel2_id", 32'(rsp_id), 32'd2);
    chk("t4_rel2_p", rsp_p, 32'h000AAE60);
    tick();
    step();

    // Reset with both stages occupied
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    rand_ops();
    repeat (2) step();
    ap_rst = 1'b1;
    #1;
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_req_ready", 32'(req_ready), 32'd0);
    chk("t6_rsp_p", rsp_p, 32'd0);
    model_reset();
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst    = 1'b0;
    rsp_ready = 1'b1;
    sample();
    chk("t6_first_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'h0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
